// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: twiddle word format and the conjugate helper
// used by both the twiddle sequencer and the complex multiplier bench.
package fft_pkg;

    localparam int TW_W     = 12;
    localparam int TW_FRAC  = 10;
    localparam int TW_PW    = 2 * TW_W;
    localparam int ROM_LOG2 = 6;

    localparam logic signed [TW_W-1:0] TW_ONE = TW_W'(1 << TW_FRAC);

    typedef logic [TW_PW-1:0] tw_word_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tw_state_e;

    // Imag half negated, real half kept; no table entry is -2048 so this never overflows.
    function automatic tw_word_t tw_conj(input tw_word_t w);
        logic [TW_W-1:0] im;
        im = -w[TW_W-1:0];
        return {w[TW_PW-1:TW_W], im};
    endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Combinational 64-point twiddle table for k = 0..31: {cos, -sin} x 1024, rounded.
module twiddle_rom
    import fft_pkg::*;
(
    input  logic [ROM_LOG2-2:0] addr,
    output tw_word_t            tw
);

    logic signed [TW_W-1:0] re;
    logic signed [TW_W-1:0] im;

    always_comb begin
        re = '0;
        im = '0;
        case (addr)
            5'd0:  begin re =  TW_ONE;    im =  12'sd0;    end
            5'd1:  begin re =  12'sd1019; im = -12'sd100;  end
            5'd2:  begin re =  12'sd1004; im = -12'sd200;  end
            5'd3:  begin re =  12'sd980;  im = -12'sd297;  end
            5'd4:  begin re =  12'sd946;  im = -12'sd392;  end
            5'd5:  begin re =  12'sd903;  im = -12'sd483;  end
            5'd6:  begin re =  12'sd851;  im = -12'sd569;  end
            5'd7:  begin re =  12'sd792;  im = -12'sd650;  end
            5'd8:  begin re =  12'sd724;  im = -12'sd724;  end
            5'd9:  begin re =  12'sd650;  im = -12'sd792;  end
            5'd10: begin re =  12'sd569;  im = -12'sd851;  end
            5'd11: begin re =  12'sd483;  im = -12'sd903;  end
            5'd12: begin re =  12'sd392;  im = -12'sd946;  end
            5'd13: begin re =  12'sd297;  im = -12'sd980;  end
            5'd14: begin re =  12'sd200;  im = -12'sd1004; end
            5'd15: begin re =  12'sd100;  im = -12'sd1019; end
            5'd16: begin re =  12'sd0;    im = -TW_ONE;    end
            5'd17: begin re = -12'sd100;  im = -12'sd1019; end
            5'd18: begin re = -12'sd200;  im = -12'sd1004; end
            5'd19: begin re = -12'sd297;  im = -12'sd980;  end
            5'd20: begin re = -12'sd392;  im = -12'sd946;  end
            5'd21: begin re = -12'sd483;  im = -12'sd903;  end
            5'd22: begin re = -12'sd569;  im = -12'sd851;  end
            5'd23: begin re = -12'sd650;  im = -12'sd792;  end
            5'd24: begin re = -12'sd724;  im = -12'sd724;  end
            5'd25: begin re = -12'sd792;  im = -12'sd650;  end
            5'd26: begin re = -12'sd851;  im = -12'sd569;  end
            5'd27: begin re = -12'sd903;  im = -12'sd483;  end
            5'd28: begin re = -12'sd946;  im = -12'sd392;  end
            5'd29: begin re = -12'sd980;  im = -12'sd297;  end
            5'd30: begin re = -12'sd1004; im = -12'sd200;  end
            5'd31: begin re = -12'sd1019; im = -12'sd100;  end
        endcase
        tw = {re, im};
    end

endmodule

// File: rtl/twiddle_gen.sv
// Radix-2 DIF twiddle sequencer: LOG2N stages of N/2 words each, streamed under
// valid/ready (a word moves when out_valid & out_ready; outputs hold while stalled).
module twiddle_gen
    import fft_pkg::*;
#(
    parameter int LOG2N = 4,
    parameter int W     = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           inverse,
    input  logic           out_ready,
    output logic           out_valid,
    output logic [2*W-1:0] tw_out,
    output logic [2:0]     out_stage,
    output logic           out_last,
    output logic           busy
);

    localparam int         HALF      = (1 << LOG2N) / 2;
    localparam int         ROM_SHIFT = ROM_LOG2 - LOG2N;
    localparam logic [4:0] J_MAX     = 5'(HALF - 1);
    localparam logic [2:0] S_MAX     = 3'(LOG2N - 1);

    tw_state_e state_q, state_d;
    logic [2:0] s_q, s_d;
    logic [4:0] j_q, j_d;
    logic       inv_q, inv_d;
    logic       out_valid_q, out_valid_d;
    tw_word_t   tw_q, tw_d;
    logic [2:0] stage_q, stage_d;
    logic       last_q, last_d;
    logic       busy_q, busy_d;

    logic       load;
    logic       use_inv;
    logic [2:0] sel_s;
    logic [4:0] sel_j;
    logic [5:0] k_mask;
    logic [5:0] k;
    logic [4:0] rom_addr;
    tw_word_t   rom_tw;

    // (s_q, j_q) always name the next word to load; a start loads word (0,0) directly.
    always_comb begin
        load    = 1'b0;
        use_inv = inv_q;
        sel_s   = s_q;
        sel_j   = j_q;
        if (state_q == ST_IDLE) begin
            if (start) begin
                load    = 1'b1;
                use_inv = inverse;
                sel_s   = '0;
                sel_j   = '0;
            end
        end else if (out_valid_q && out_ready && !last_q) begin
            load = 1'b1;
        end
    end

    always_comb begin
        k_mask   = (6'(HALF) >> sel_s) - 6'd1;
        k        = ({1'b0, sel_j} & k_mask) << sel_s;
        rom_addr = 5'(k << ROM_SHIFT);
    end

    twiddle_rom u_rom (
        .addr (rom_addr),
        .tw   (rom_tw)
    );

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        j_d         = j_q;
        inv_d       = inv_q;
        out_valid_d = out_valid_q;
        tw_d        = tw_q;
        stage_d     = stage_q;
        last_d      = last_q;
        busy_d      = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    inv_d   = inverse;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (out_valid_q && out_ready && last_q) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    last_d      = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            out_valid_d = 1'b1;
            tw_d        = use_inv ? tw_conj(rom_tw) : rom_tw;
            stage_d     = sel_s;
            last_d      = (sel_s == S_MAX) && (sel_j == J_MAX);
            if (sel_j == J_MAX) begin
                j_d = '0;
                s_d = sel_s + 3'd1;
            end else begin
                j_d = sel_j + 5'd1;
                s_d = sel_s;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            j_q         <= '0;
            inv_q       <= 1'b0;
            out_valid_q <= 1'b0;
            tw_q        <= '0;
            stage_q     <= '0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            j_q         <= j_d;
            inv_q       <= inv_d;
            out_valid_q <= out_valid_d;
            tw_q        <= tw_d;
            stage_q     <= stage_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign tw_out    = tw_q;
    assign out_stage = stage_q;
    assign out_last  = last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_twiddle_gen.sv
// Scoreboard bench for twiddle_gen: N=16 main instance plus N=8 and N=64 builds.
module tb_twiddle_gen;

    logic        clk = 1'b0;
    logic        rst, start, inverse, out_ready;
    logic        out_valid, out_last, busy;
    logic [23:0] tw_out;
    logic [2:0]  out_stage;

    logic        start3, valid3, last3, busy3;
    logic [23:0] tw3;
    logic [2:0]  stage3;
    logic        start6, valid6, last6, busy6;
    logic [23:0] tw6;
    logic [2:0]  stage6;
    logic        one = 1'b1;
    logic        zero = 1'b0;

    always #5 clk = ~clk;

    twiddle_gen #(.LOG2N(4)) dut (
        .clk(clk), .rst(rst), .start(start), .inverse(inverse), .out_ready(out_ready),
        .out_valid(out_valid), .tw_out(tw_out), .out_stage(out_stage),
        .out_last(out_last), .busy(busy)
    );

    twiddle_gen #(.LOG2N(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .inverse(zero), .out_ready(one),
        .out_valid(valid3), .tw_out(tw3), .out_stage(stage3),
        .out_last(last3), .busy(busy3)
    );

    twiddle_gen #(.LOG2N(6)) dut6 (
        .clk(clk), .rst(rst), .start(start6), .inverse(zero), .out_ready(one),
        .out_valid(valid6), .tw_out(tw6), .out_stage(stage6),
        .out_last(last6), .busy(busy6)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [27:0] exp_q[$];

    // Hand-computed 16-point twiddles k=0..7: cos*1024 and -sin*1024 as 12-bit hex.
    logic [11:0] ref_re [8] = '{12'h400, 12'h3B2, 12'h2D4, 12'h188, 12'h000, 12'hE78, 12'hD2C, 12'hC4E};
    logic [11:0] ref_im [8] = '{12'h000, 12'hE78, 12'hD2C, 12'hC4E, 12'hC00, 12'hC4E, 12'hD2C, 12'hE78};
    int k_tab [32] = '{0, 1, 2, 3, 4, 5, 6, 7,
                       0, 2, 4, 6, 0, 2, 4, 6,
                       0, 4, 0, 4, 0, 4, 0, 4,
                       0, 0, 0, 0, 0, 0, 0, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_seq(input logic inv);
        logic [11:0] im;
        for (int i = 0; i < 32; i++) begin
            im = inv ? 12'(-ref_im[k_tab[i]]) : ref_im[k_tab[i]];
            exp_q.push_back({(i == 31), 3'(i / 8), ref_re[k_tab[i]], im});
        end
    endtask

    // ---------------- clock/reset and ready driver ----------------
    logic rand_en   = 1'b0;
    logic ready_fix = 1'b1;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rand_en ? 1'($urandom_range(0, 1)) : ready_fix;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int          acc_cnt = 0;
    logic        hold_pending = 1'b0;
    logic        last_done = 1'b0;
    logic [27:0] held;
    logic [27:0] e;

    always @(negedge clk) begin
        if (rst) begin
            hold_pending = 1'b0;
            last_done    = 1'b0;
        end else begin
            if (hold_pending && out_valid)
                chk("stall_hold", 32'({out_last, out_stage, tw_out}), 32'(held));
            if (last_done) begin
                chk("busy_after_last", 32'(busy), 32'd0);
                chk("valid_after_last", 32'(out_valid), 32'd0);
                last_done = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h expected none", tw_out);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("word%0d", acc_cnt), 32'({out_last, out_stage, tw_out}), 32'(e));
                end
                acc_cnt++;
                if (out_last) last_done = 1'b1;
            end
            hold_pending = out_valid && !out_ready;
            held         = {out_last, out_stage, tw_out};
        end
    end

    int          cnt3 = 0, cnt6 = 0, last_idx3 = -1, last_idx6 = -1;
    logic [23:0] w3_1 = '0, w6_16 = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid3) begin
                if (cnt3 == 1) w3_1 = tw3;
                if (last3) last_idx3 = cnt3;
                cnt3++;
            end
            if (valid6) begin
                if (cnt6 == 16) w6_16 = tw6;
                if (last6) last_idx6 = cnt6;
                cnt6++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start(input logic inv);
        @(posedge clk); #1;
        start   = 1'b1;
        inverse = inv;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk(name, 32'(t >= 500), 32'd0);
        repeat (2) @(posedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int t;
        rst = 1'b1; start = 1'b0; inverse = 1'b0; start3 = 1'b0; start6 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_tw", 32'(tw_out), 32'd0);
        chk("rst_stage", 32'(out_stage), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Plain forward run with latency check
        push_seq(1'b0);
        @(posedge clk); #1;
        start = 1'b1;
        @(negedge clk);
        chk("valid_before_start", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("first_busy", 32'(busy), 32'd1);
        wait_done("done_plain");

        // Inverse run; inverse dropped mid-run must not matter
        push_seq(1'b1);
        pulse_start(1'b1);
        repeat (4) @(posedge clk);
        #1 inverse = 1'b0;
        wait_done("done_inverse");

        // Random backpressure with stray start pulses during the run
        rand_en = 1'b1;
        push_seq(1'b0);
        pulse_start(1'b0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            start = (i % 7 == 3) && busy;
        end
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("done_backpressure");
        rand_en = 1'b0;

        // Reset after word 10, then replay from word 0
        push_seq(1'b0);
        base = acc_cnt;
        pulse_start(1'b0);
        t = 0;
        while (acc_cnt < base + 11 && t < 200) begin
            @(posedge clk);
            t++;
        end
        chk("mid_reset_reach", 32'(t >= 200), 32'd0);
        #1;
        rst       = 1'b1;
        ready_fix = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_tw", 32'(tw_out), 32'd0);
        chk("mrst_stage", 32'(out_stage), 32'd0);
        chk("mrst_last", 32'(out_last), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst       = 1'b0;
        ready_fix = 1'b1;
        push_seq(1'b0);
        pulse_start(1'b0);
        wait_done("done_replay");

        // N=8 and N=64 builds
        @(posedge clk); #1;
        start3 = 1'b1; start6 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0; start6 = 1'b0;
        t = 0;
        while ((busy3 || busy6) && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("done_sizes", 32'(t >= 400), 32'd0);
        repeat (2) @(posedge clk);
        chk("n8_count", 32'(cnt3), 32'd12);
        chk("n64_count", 32'(cnt6), 32'd192);
        chk("n8_j1", 32'(w3_1), 32'h2D4D2C);
        chk("n64_j16", 32'(w6_16), 32'h000C00);
        chk("n8_last_idx", 32'(last_idx3), 32'd11);
        chk("n64_last_idx", 32'(last_idx6), 32'd191);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
